// File: rtl/somador_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: controller state encodings
// and the default operand width.
package somador_serial_ctrl_pkg;

    // Default operand/result width in bits (must be >= 2).
    localparam int DEFAULT_WIDTH = 8;

    // Controller states. The encodings are fixed so that other blocks and
    // debug tooling can decode the state register directly.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : somador_serial_ctrl_pkg

// File: rtl/somador_serial_ctrl_completo.sv
// completo: single-bit full-adder cell. It is purely combinational; the
// serial controller registers the carry between successive bit positions.
module completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic a_xor_b;

    // Propagate term, shared by the sum and carry equations.
    assign a_xor_b = a ^ b;

    // Sum bit of the three inputs.
    assign s = a_xor_b ^ cin;

    // Generate when both operand bits are set; propagate the incoming carry
    // when exactly one operand bit is set.
    assign cout = (a & b) | (cin & a_xor_b);

endmodule : completo

// File: rtl/somador_serial_ctrl.sv
// somador_serial_ctrl: bit-serial adder built around one full-adder cell.
// A start request loads both operands and the initial carry. The operand
// bits then flow LSB first through `completo`, one bit per clock, and after
// WIDTH steps the result, carry-out and signed overflow are presented
// together with a one-cycle done pulse. Results stay stable until the next
// add completes.
module somador_serial_ctrl
    import somador_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // The step counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are
    // enough. WIDTH >= 2 keeps this at least one bit wide.
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry_q;

    // Full-adder cell outputs for the bit currently in flight.
    logic               fa_s;
    logic               fa_cout;

    // Decoded control conditions.
    logic               accept;
    logic               last_step;
    logic               shifting;

    // A request is honoured in IDLE and in DONE (back-to-back adds); while
    // an add is running the request line is ignored and the operands are
    // not re-sampled.
    assign accept    = start && (state != SHIFT);
    assign shifting  = (state == SHIFT);
    assign last_step = shifting && (cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // The one and only full-adder cell. It always sees the LSBs of the
    // operand shift registers and the carry left by the previous step.
    // ------------------------------------------------------------------
    completo u_completo (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Controller: state, step counter and the registered busy/done flags.
    // NOTE: every register is written with non-blocking assignments so that
    // all flops sample the values from before the edge, independent of the
    // order of statements or always blocks; a blocking assignment here would
    // let one register see another's new value within the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    cnt  <= '0;
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        // The MSB step has just been taken: present the result.
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    cnt  <= '0;
                    if (start) begin
                        // Back-to-back request: start the next add immediately.
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    // Unused encoding: return to a known, quiet state.
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand load, one bit per step through the adder cell, and
    // the result capture on the MSB step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            sum_sr  <= '0;
            carry_q <= cin;
        end else if (shifting) begin
            // Operands move right so the next bit lands in position 0; the
            // sum bit enters at the top so that after WIDTH steps the LSB
            // has reached bit 0.
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
            carry_q <= fa_cout;
            if (last_step) begin
                // carry_q is the carry into the MSB here, so comparing it
                // with the carry out of the MSB gives signed overflow.
                sum  <= {fa_s, sum_sr[WIDTH-1:1]};
                cout <= fa_cout;
                ovf  <= carry_q ^ fa_cout;
            end
        end
    end

endmodule : somador_serial_ctrl

// File: tb/tb_somador_serial_ctrl.sv
// Directed testbench for the 8-bit bit-serial adder controller.
module tb_somador_serial_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    somador_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the operand inputs.
    // Returns at the falling edge right after the accepting rising edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Count falling edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        launch(a, b, ci);
        wait_done(n);
        check({tag, ".latency"}, n, 8);
        check({tag, ".sum"}, sum, es);
        check({tag, ".cout"}, cout, ec);
        check({tag, ".ovf"}, ovf, eo);
        @(negedge clk);
        check({tag, ".done_width"}, done, 0);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [W-1:0] ra, rb, es;
        logic        rc, ec, eo;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.sum",  sum,  0);
        check("rst.cout", cout, 0);
        check("rst.ovf",  ovf,  0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zero + zero, busy for exactly 8 cycles then done.
        launch(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1.busy%0d", i), busy, 1);
            check($sformatf("t1.nodone%0d", i), done, 0);
            @(negedge clk);
        end
        check("t1.done", done, 1);
        check("t1.busy_off", busy, 0);
        check("t1.sum", sum, 8'h00);
        check("t1.cout", cout, 0);
        check("t1.ovf", ovf, 0);
        @(negedge clk);
        check("t1.done_width", done, 0);

        // 2: FF + 01 wraps with carry out, no signed overflow.
        do_add("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("t2.hold_sum", sum, 8'h00);
        check("t2.hold_cout", cout, 1);

        // 3: 7F + 01 overflows signed; A5 + 5A + 1 wraps to zero.
        do_add("t3a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_add("t3b", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // 4: start held through busy with op_a changed, then accepted in DONE.
        @(negedge clk);
        op_a  = 8'h12;
        op_b  = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        op_a  = 8'h33;
        wait_done(n);
        check("t4.latency1", n, 8);
        check("t4.sum1", sum, 8'h46);
        check("t4.cout1", cout, 0);
        @(negedge clk);
        check("t4.b2b_busy", busy, 1);
        check("t4.b2b_done", done, 0);
        start = 1'b0;
        op_a  = 8'h00;
        wait_done(n);
        check("t4.latency2", n, 8);
        check("t4.sum2", sum, 8'h67);
        check("t4.cout2", cout, 0);
        check("t4.ovf2", ovf, 0);
        @(negedge clk);

        // 5: reset pulse in the middle of an add.
        launch(8'h55, 8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5.busy", busy, 0);
        check("t5.done", done, 0);
        check("t5.sum", sum, 8'h00);
        check("t5.cout", cout, 0);
        check("t5.ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("t5.no_done", seen, 0);
        check("t5.sum_after", sum, 8'h00);
        do_add("t5.next", 8'h55, 8'h0F, 1'b1, 8'h65, 1'b0, 1'b0);

        // 6: random adds against a reference model.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            {ec, es} = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
            do_add($sformatf("t6.%0d", i), ra, rb, rc, es, ec, eo);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_somador_serial_ctrl
